vga_pattern_seq: RTL and testbench
==================================

// Module: vga_pattern_seq
// PURPOSE
//  Frame-synchronous test-pattern scheduler feeding the VGA timing controller's jpg_colour input.
//  Computes the colour for the current jpg_x/jpg_y from the active pattern mode.
//  Advances the mode on a debounced key press or automatically every FRAMES_PER_MODE frames.
//  Mode changes only at frame boundaries, so no frame ever shows a torn pattern.
// PARAMETERS
//  FRAMES_PER_MODE  60        frames each mode is held when auto_en=1 (legal range 1..1023)
//  DEB_CYCLES       500000    Clk_int cycles the key level must be stable (20 ms at 25 MHz)
//  SOLID_COLOUR     16'h001F  RGB565 colour of the SOLID mode
// PORTS
//  Clk_int     in   1   pixel clock; single clock domain
//  Sys_Rst_n   in   1   reset, asynchronous, active-low
//  V_sys       in   1   field sync from timing controller; high during the 2 sync lines
//  jpg_x       in   10  active-area x coordinate 0..639 (0 outside active area)
//  jpg_y       in   10  active-area y coordinate 0..479 (0 outside active area)
//  key_n       in   1   raw push-button, active-low, asynchronous to Clk_int
//  auto_en     in   1   1 = auto-advance every FRAMES_PER_MODE frames
//  jpg_colour  out  16  RGB565 pixel colour for (jpg_x, jpg_y)
//  mode        out  2   current pattern mode
//  frame_tick  out  1   one-cycle pulse at the start of each frame
// BEHAVIOUR
//  Reset values: mode=0 (BARS), frame_tick=0, frame counter=0, pending=0.
//   v_sys_q=1, key sync FFs=1, debounced level=1 (released), debounce counter=0.
//  Frame edge: v_sys_q <= V_sys.
//   frame_tick <= V_sys & ~v_sys_q, so it is registered and high for exactly 1 cycle.
//   It asserts the cycle after V_sys is first sampled high.
//   v_sys_q resets to 1, so no tick occurs for the frame in progress at reset release.
//  Key path: 2-FF synchroniser, then debounce.
//   The counter clears whenever the synced level equals the debounced level.
//   Otherwise it increments; at DEB_CYCLES-1 the debounced level flips and the counter clears.
//   press = 1-cycle pulse on the debounced 1->0 transition. Releases generate nothing.
//  pending: set by press, cleared by an advance.
//   press and advance in the same cycle -> pending stays 1, and that press serves the next frame.
//   Any number of presses within one frame collapse to a single advance.
//  Mode FSM states: BARS(0) -> GRID(1) -> GRAD(2) -> SOLID(3) -> BARS; transitions only when frame_tick=1.
//   adv = frame_tick & (pending | (auto_en & frame_cnt==FRAMES_PER_MODE-1)).
//   On adv: mode <= mode+1 (2-bit wrap), frame_cnt <= 0.
//   On frame_tick without adv: frame_cnt <= auto_en ? frame_cnt+1 : 0.
//   FRAMES_PER_MODE=1 with auto_en=1 advances on every tick.
//  jpg_colour: combinational from the registered mode, jpg_x and jpg_y.
//   Zero latency, so it aligns with the controller's combinational gating.
//   BARS: 8 bars, each 80 px wide, selected by comparator chain on jpg_x (no divider).
//    Colours left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
//   GRID: FFFF if jpg_x[4:0]==0 or jpg_y[4:0]==0, else 0000.
//   GRAD: {jpg_x[9:5], jpg_y[8:3], 5'b00000}.
//   SOLID: SOLID_COLOUR.
//   Outside the active area the inputs are 0 and the controller blanks the output; no special case here.
//  Reset mid-frame: all state returns to reset values immediately. mode=0 from the first post-reset pixel.
// STRUCTURE
//  Shared package/include vga_pkg:
//   MODE_BARS..MODE_SOLID encodings.
//   RGB565 colour constants (WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK).
//   H_VALID=640, V_VALID=480.
//  Sub-module key_debounce (parameter DEB_CYCLES; ports Clk_int, Sys_Rst_n, key_n, press): sync + debounce + edge detect.
//  Top level holds the frame-edge detector, the pending flag, the mode FSM, the frame counter and the colour mux.
// TESTING (DEB_CYCLES=8, FRAMES_PER_MODE=3 in bench)
//  Reset then hold V_sys=1 -> no frame_tick.
//   Drive V_sys 0 then 1 -> frame_tick high exactly 1 cycle, on the cycle after V_sys rises.
//  auto_en=1, 7 frame ticks -> mode sequence 0,0,0,1,1,1,2.
//   mode changes in the cycle after the 3rd and 6th ticks.
//  auto_en=0, key_n low 5 cycles -> no press.
//   key_n low 20 cycles -> exactly one advance, at the next frame_tick only.
//  3 debounced presses within one frame -> single mode increment.
//   Press landing on the tick cycle -> advance now plus one more at the next tick.
//  Colour checks:
//   BARS (x,y)=(79,0) -> FFFF; (80,0) -> FFE0; (639,479) -> 0000.
//   GRID (32,7) -> FFFF; (33,7) -> 0000.
//   GRAD (639,479) -> {5'd19, 6'd59, 5'd0} = 9F60.
//   SOLID -> 001F.
//  Assert Sys_Rst_n low mid-frame while in mode 2 with pending=1 -> mode=0, pending=0, frame_tick=0 immediately.
//   No tick in the first post-reset frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared encodings, geometry and RGB565 palette for the VGA test-pattern path.
package vga_pkg;

    localparam int unsigned MODE_W   = 2;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COLOUR_W = 16;
    localparam int unsigned H_VALID  = 640;
    localparam int unsigned V_VALID  = 480;
    localparam int unsigned BAR_W    = H_VALID / 8;

    localparam logic [MODE_W-1:0] MODE_BARS  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_GRID  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_GRAD  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SOLID = 2'd3;

    localparam logic [COLOUR_W-1:0] WHITE   = 16'hFFFF;
    localparam logic [COLOUR_W-1:0] YELLOW  = 16'hFFE0;
    localparam logic [COLOUR_W-1:0] CYAN    = 16'h07FF;
    localparam logic [COLOUR_W-1:0] GREEN   = 16'h07E0;
    localparam logic [COLOUR_W-1:0] MAGENTA = 16'hF81F;
    localparam logic [COLOUR_W-1:0] RED     = 16'hF800;
    localparam logic [COLOUR_W-1:0] BLUE    = 16'h001F;
    localparam logic [COLOUR_W-1:0] BLACK   = 16'h0000;

    // Eight equal-width colour bars picked by a comparator chain, avoiding a divider.
    function automatic logic [COLOUR_W-1:0] bar_colour(input logic [COORD_W-1:0] x);
        logic [COLOUR_W-1:0] c;
        if      (x < COORD_W'(1 * BAR_W)) c = WHITE;
        else if (x < COORD_W'(2 * BAR_W)) c = YELLOW;
        else if (x < COORD_W'(3 * BAR_W)) c = CYAN;
        else if (x < COORD_W'(4 * BAR_W)) c = GREEN;
        else if (x < COORD_W'(5 * BAR_W)) c = MAGENTA;
        else if (x < COORD_W'(6 * BAR_W)) c = RED;
        else if (x < COORD_W'(7 * BAR_W)) c = BLUE;
        else                              c = BLACK;
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser, stability debouncer and press (1->0) pulse generator.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic Clk_int,
    input  logic Sys_Rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q,   deb_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Counter runs only while the synced level disagrees with the debounced one.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = deb_q & ~deb_d;
    end

    assign press = press_q;

endmodule

// File: rtl/vga_pattern_seq.sv
// Frame-synchronous test-pattern scheduler: mode FSM advanced by key or timer, colour mux per pixel.
module vga_pattern_seq
    import vga_pkg::*;
#(
    parameter int unsigned         FRAMES_PER_MODE = 60,
    parameter int unsigned         DEB_CYCLES      = 500000,
    parameter logic [COLOUR_W-1:0] SOLID_COLOUR    = 16'h001F
) (
    input  logic                Clk_int,
    input  logic                Sys_Rst_n,
    input  logic                V_sys,
    input  logic [COORD_W-1:0]  jpg_x,
    input  logic [COORD_W-1:0]  jpg_y,
    input  logic                key_n,
    input  logic                auto_en,
    output logic [COLOUR_W-1:0] jpg_colour,
    output logic [MODE_W-1:0]   mode,
    output logic                frame_tick
);

    localparam int unsigned        FCNT_W    = 10;
    localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FRAMES_PER_MODE - 1);

    logic              v_sys_q,      v_sys_d;
    logic              frame_tick_q, frame_tick_d;
    logic              pending_q,    pending_d;
    logic [MODE_W-1:0] mode_q,       mode_d;
    logic [FCNT_W-1:0] frame_cnt_q,  frame_cnt_d;
    logic              press;
    logic              adv;
    logic              unused_y_msb;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .Clk_int   (Clk_int),
        .Sys_Rst_n (Sys_Rst_n),
        .key_n     (key_n),
        .press     (press)
    );

    // v_sys_q resets high so the frame already in progress at reset release never ticks.
    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            v_sys_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            pending_q    <= 1'b0;
            mode_q       <= MODE_BARS;
            frame_cnt_q  <= '0;
        end else begin
            v_sys_q      <= v_sys_d;
            frame_tick_q <= frame_tick_d;
            pending_q    <= pending_d;
            mode_q       <= mode_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // A press coinciding with an advance is kept pending for the following frame.
    always_comb begin
        v_sys_d      = V_sys;
        frame_tick_d = V_sys & ~v_sys_q;
        mode_d       = mode_q;
        frame_cnt_d  = frame_cnt_q;
        adv          = frame_tick_q & (pending_q | (auto_en & (frame_cnt_q == FCNT_LAST)));
        pending_d    = press | (pending_q & ~adv);
        if (adv) begin
            case (mode_q)
                MODE_BARS: mode_d = MODE_GRID;
                MODE_GRID: mode_d = MODE_GRAD;
                MODE_GRAD: mode_d = MODE_SOLID;
                default:   mode_d = MODE_BARS;
            endcase
            frame_cnt_d = '0;
        end else if (frame_tick_q) begin
            frame_cnt_d = auto_en ? frame_cnt_q + FCNT_W'(1) : '0;
        end
    end

    // Zero-latency colour so it lines up with the controller's combinational blanking.
    always_comb begin
        jpg_colour = BLACK;
        case (mode_q)
            MODE_BARS: jpg_colour = bar_colour(jpg_x);
            MODE_GRID: jpg_colour = ((jpg_x[4:0] == 5'd0) || (jpg_y[4:0] == 5'd0)) ? WHITE : BLACK;
            MODE_GRAD: jpg_colour = {jpg_x[9:5], jpg_y[8:3], 5'b00000};
            default:   jpg_colour = SOLID_COLOUR;
        endcase
    end

    assign unused_y_msb = jpg_y[9];
    assign mode         = mode_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_seq.sv
// Scoreboard bench for vga_pattern_seq: frame ticks, auto/key mode advance, colours, mid-frame reset.
module tb_vga_pattern_seq;

    localparam int unsigned FPM = 3;
    localparam int unsigned DEB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_sys = 1'b1;
    logic        key_n = 1'b1;
    logic        auto_en = 1'b0;
    logic [9:0]  jx = '0;
    logic [9:0]  jy = '0;
    logic [15:0] colour;
    logic [1:0]  mode;
    logic        tick;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model of the mode scheduler.
    int   m_mode = 0;
    int   m_cnt = 0;
    bit   m_pending = 1'b0;

    vga_pattern_seq #(
        .FRAMES_PER_MODE (FPM),
        .DEB_CYCLES      (DEB),
        .SOLID_COLOUR    (16'h001F)
    ) dut (
        .Clk_int    (clk),
        .Sys_Rst_n  (rst_n),
        .V_sys      (v_sys),
        .jpg_x      (jx),
        .jpg_y      (jy),
        .key_n      (key_n),
        .auto_en    (auto_en),
        .jpg_colour (colour),
        .mode       (mode),
        .frame_tick (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic colour_at(input string tag, input int x, input int y, input logic [15:0] exp);
        push_exp(tag, 32'(exp));
        jx = 10'(x);
        jy = 10'(y);
        #1;
        pop_chk(32'(colour));
    endtask

    task automatic no_tick_for(input string tag, input int n);
        int seen;
        seen = 0;
        push_exp(tag, 32'd0);
        repeat (n) begin
            @(negedge clk);
            seen += int'(tick);
        end
        pop_chk(32'(seen));
    endtask

    // Raise V_sys (caller holds it low at a negedge); check the one-cycle tick and the mode step.
    task automatic frame_edge(input bit press_now);
        bit adv;
        v_sys = 1'b1;
        @(negedge clk);
        push_exp("tick_hi", 32'd1);
        push_exp("mode_at_tick", 32'(m_mode));
        pop_chk(32'(tick));
        pop_chk(32'(mode));
        adv = m_pending || (auto_en && (m_cnt == int'(FPM) - 1));
        if (adv) begin
            m_mode = (m_mode + 1) % 4;
            m_cnt = 0;
            m_pending = 1'b0;
        end else begin
            m_cnt = auto_en ? m_cnt + 1 : 0;
        end
        if (press_now) m_pending = 1'b1;
        @(negedge clk);
        push_exp("tick_lo", 32'd0);
        push_exp("mode_after", 32'(m_mode));
        pop_chk(32'(tick));
        pop_chk(32'(mode));
        repeat (3) @(negedge clk);
    endtask

    task automatic frame();
        v_sys = 1'b0;
        repeat (4) @(negedge clk);
        frame_edge(1'b0);
    endtask

    task automatic press_key();
        key_n = 1'b0;
        repeat (20) @(negedge clk);
        key_n = 1'b1;
        repeat (20) @(negedge clk);
        m_pending = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        push_exp("rst_mode", 32'd0);
        pop_chk(32'(mode));
        push_exp("rst_tick", 32'd0);
        pop_chk(32'(tick));
        colour_at("rst_colour", 0, 0, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;

        // V_sys high across reset release must not tick.
        no_tick_for("no_tick_initial", 6);
        frame();

        // Auto-advance every FPM frames.
        auto_en = 1'b1;
        repeat (7) frame();
        auto_en = 1'b0;
        colour_at("grad_639_479", 639, 479, 16'h9F60);

        // Short glitch is filtered, long press advances at the next tick only.
        key_n = 1'b0;
        repeat (5) @(negedge clk);
        key_n = 1'b1;
        repeat (20) @(negedge clk);
        frame();
        press_key();
        push_exp("mode_hold_before_tick", 32'(m_mode));
        pop_chk(32'(mode));
        frame();
        frame();
        colour_at("solid", 100, 200, 16'h001F);

        // Three presses in one frame collapse into one advance.
        press_key();
        press_key();
        press_key();
        frame();
        frame();
        colour_at("bars_79_0", 79, 0, 16'hFFFF);
        colour_at("bars_80_0", 80, 0, 16'hFFE0);
        colour_at("bars_639_479", 639, 479, 16'h0000);

        // Pending press plus a new press landing on the tick cycle.
        press_key();
        v_sys = 1'b0;
        repeat (4) @(negedge clk);
        key_n = 1'b0;
        repeat (9) @(negedge clk);
        frame_edge(1'b1);
        key_n = 1'b1;
        colour_at("grid_32_7", 32, 7, 16'hFFFF);
        colour_at("grid_33_7", 33, 7, 16'h0000);
        repeat (20) @(negedge clk);
        frame();
        frame();

        // Mid-frame reset in GRAD with a press pending.
        press_key();
        push_exp("mode_before_rst", 32'd2);
        pop_chk(32'(mode));
        jx = 10'd0;
        jy = 10'd0;
        v_sys = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("midrst_mode", 32'd0);
        pop_chk(32'(mode));
        push_exp("midrst_tick", 32'd0);
        pop_chk(32'(tick));
        push_exp("midrst_colour", 32'h0000FFFF);
        pop_chk(32'(colour));
        m_mode = 0;
        m_cnt = 0;
        m_pending = 1'b0;
        @(negedge clk);
        v_sys = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        no_tick_for("no_tick_post_rst", 8);
        frame();

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
